// File: rtl/reg_bank_pkg.sv
// Shared defaults for the register bank: geometry, reset image and index names
// for the exported low registers.
package reg_bank_pkg;

  localparam int unsigned DEF_DATAWIDTH = 8;
  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_ADDR      = 4;
  localparam int unsigned DEF_NUM_EXP   = 4;

  localparam int unsigned REG_IDX_0 = 0;
  localparam int unsigned REG_IDX_1 = 1;
  localparam int unsigned REG_IDX_2 = 2;
  localparam int unsigned REG_IDX_3 = 3;

  localparam int unsigned DEF_RST_W = DEF_DEPTH * DEF_DATAWIDTH;

  // Reg 2 powers up to 0x21, reg 3 to 0x08, everything else clears.
  localparam logic [DEF_RST_W-1:0] DEF_RST_VAL =
      (DEF_RST_W'(8'h21) << (REG_IDX_2 * DEF_DATAWIDTH)) |
      (DEF_RST_W'(8'h08) << (REG_IDX_3 * DEF_DATAWIDTH));

endpackage

// File: rtl/reg_bank.sv
// Parameterised register bank: single-cycle writes, latency-1 reads with
// read-before-write, per-register read-only mask and low registers exported.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned ADDR      = DEF_ADDR,
  parameter int unsigned NUM_EXP   = DEF_NUM_EXP,
  parameter logic [DEPTH-1:0] RO_MASK = '0,
  parameter logic [DEPTH*DATAWIDTH-1:0] RST_VAL = (DEPTH*DATAWIDTH)'(DEF_RST_VAL)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [ADDR-1:0]              Address,
  input  logic                         WrEn,
  input  logic                         RdEn,
  input  logic [DATAWIDTH-1:0]         WrData,
  output logic [DATAWIDTH-1:0]         RdData,
  output logic                         RdData_Valid,
  output logic                         Err,
  output logic [NUM_EXP*DATAWIDTH-1:0] REG_EXP,
  output logic [NUM_EXP-1:0]           REG_UPD
);

  localparam logic [ADDR:0] DEPTH_W = (ADDR+1)'(DEPTH);

  logic [DATAWIDTH-1:0] regs [DEPTH];
  logic [DATAWIDTH-1:0] rd_word;
  logic                 in_range;
  logic                 ro_hit;
  logic                 wr_ok;

  assign in_range = {1'b0, Address} < DEPTH_W;

  // Decode by comparison rather than indexing so DEPTH need not fill the
  // address space and out-of-range addresses select nothing.
  always_comb begin
    rd_word = '0;
    ro_hit  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (Address == ADDR'(i)) begin
        rd_word = regs[i];
        ro_hit  = RO_MASK[i];
      end
    end
  end

  assign wr_ok = WrEn & in_range & ~ro_hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= RST_VAL[i*DATAWIDTH +: DATAWIDTH];
      end
      RdData       <= '0;
      RdData_Valid <= 1'b0;
      Err          <= 1'b0;
      REG_UPD      <= '0;
    end else begin
      RdData_Valid <= RdEn;
      if (RdEn) begin
        RdData <= in_range ? rd_word : '0;
      end
      // A combined access with either side rejected still yields one pulse.
      Err <= (RdEn & ~in_range) | (WrEn & ~wr_ok);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_ok && (Address == ADDR'(i))) begin
          regs[i] <= WrData;
        end
      end
      for (int unsigned i = 0; i < NUM_EXP; i++) begin
        REG_UPD[i] <= wr_ok && (Address == ADDR'(i));
      end
    end
  end

  always_comb begin
    REG_EXP = '0;
    for (int unsigned i = 0; i < NUM_EXP; i++) begin
      REG_EXP[i*DATAWIDTH +: DATAWIDTH] = regs[i];
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank (DEPTH=12, reg 3 read-only) with a behavioural
// memory model checked every cycle plus literal spot checks.
module tb_reg_bank;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  Address = '0;
  logic        WrEn = 1'b0;
  logic        RdEn = 1'b0;
  logic [7:0]  WrData = '0;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic        Err;
  logic [31:0] REG_EXP;
  logic [3:0]  REG_UPD;

  reg_bank #(
    .DATAWIDTH(8),
    .DEPTH(12),
    .ADDR(4),
    .NUM_EXP(4),
    .RO_MASK(12'h008)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Address(Address),
    .WrEn(WrEn),
    .RdEn(RdEn),
    .WrData(WrData),
    .RdData(RdData),
    .RdData_Valid(RdData_Valid),
    .Err(Err),
    .REG_EXP(REG_EXP),
    .REG_UPD(REG_UPD)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  logic [7:0]  mem [12];
  logic [7:0]  exp_rd;
  logic        exp_valid;
  logic        exp_err;
  logic [3:0]  exp_upd;
  logic [31:0] exp_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One bus cycle: drive on the falling edge, predict from the rules, and
  // publish the prediction at the rising edge.
  task automatic step(input logic rst, input logic we, input logic re,
                      input logic [3:0] addr, input logic [7:0] wd);
    logic [7:0] n_rd;
    logic       n_valid, n_err, inr, wok;
    logic [3:0] n_upd;
    @(negedge CLK);
    RST = rst; WrEn = we; RdEn = re; Address = addr; WrData = wd;
    n_rd = exp_rd;
    if (rst) begin
      foreach (mem[i]) mem[i] = 8'h00;
      mem[2] = 8'h21;
      mem[3] = 8'h08;
      n_rd = 8'h00; n_valid = 1'b0; n_err = 1'b0; n_upd = 4'h0;
    end else begin
      inr = (addr < 12);
      wok = we && inr && (addr != 3);
      n_valid = re;
      if (re) n_rd = inr ? mem[addr] : 8'h00;
      n_err = (re && !inr) || (we && !wok);
      n_upd = (wok && addr < 4) ? (4'h1 << addr) : 4'h0;
      if (wok) mem[addr] = wd;
    end
    @(posedge CLK);
    exp_rd = n_rd; exp_valid = n_valid; exp_err = n_err; exp_upd = n_upd;
    exp_exp = {mem[3], mem[2], mem[1], mem[0]};
    checking = 1'b1;
  endtask

  always @(posedge CLK) begin
    #1;
    if (checking) begin
      chk("rd_data", {24'h0, RdData}, {24'h0, exp_rd});
      chk("rd_valid", {31'h0, RdData_Valid}, {31'h0, exp_valid});
      chk("err", {31'h0, Err}, {31'h0, exp_err});
      chk("reg_upd", {28'h0, REG_UPD}, {28'h0, exp_upd});
      chk("reg_exp", REG_EXP, exp_exp);
    end
  end

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    #2;
    chk("lit_rst_exp", REG_EXP, 32'h0821_0000);
    chk("lit_rst_rd", {24'h0, RdData}, 32'h0);

    // reset values readable with a one-cycle valid
    step(1'b0, 1'b0, 1'b1, 4'd2, 8'h00); #2;
    chk("lit_rd2", {23'h0, RdData_Valid, RdData}, {23'h0, 1'b1, 8'h21});
    step(1'b0, 1'b0, 1'b1, 4'd3, 8'h00); #2;
    chk("lit_rd3", {24'h0, RdData}, 32'h08);
    idle(); #2;
    chk("lit_hold", {23'h0, RdData_Valid, RdData}, {23'h0, 1'b0, 8'h08});

    // write then read back
    step(1'b0, 1'b1, 1'b0, 4'd1, 8'hA5); #2;
    chk("lit_upd1", {28'h0, REG_UPD}, 32'h2);
    chk("lit_exp1", {24'h0, REG_EXP[15:8]}, 32'hA5);
    step(1'b0, 1'b0, 1'b1, 4'd1, 8'h00); #2;
    chk("lit_rd1", {24'h0, RdData}, 32'hA5);

    // read-before-write
    step(1'b0, 1'b1, 1'b0, 4'd5, 8'h11);
    step(1'b0, 1'b1, 1'b1, 4'd5, 8'h3C); #2;
    chk("lit_rbw", {24'h0, RdData}, 32'h11);
    step(1'b0, 1'b0, 1'b1, 4'd5, 8'h00); #2;
    chk("lit_rbw2", {24'h0, RdData}, 32'h3C);

    // read-only register
    step(1'b0, 1'b1, 1'b0, 4'd3, 8'hFF); #2;
    chk("lit_ro_err", {27'h0, Err, REG_UPD}, {27'h0, 1'b1, 4'h0});
    idle();
    step(1'b0, 1'b0, 1'b1, 4'd3, 8'h00); #2;
    chk("lit_ro_keep", {24'h0, RdData}, 32'h08);

    // out-of-range addresses and the DEPTH boundary
    step(1'b0, 1'b0, 1'b1, 4'd13, 8'h00); #2;
    chk("lit_oor_rd", {22'h0, Err, RdData_Valid, RdData}, {22'h0, 2'b11, 8'h00});
    step(1'b0, 1'b1, 1'b0, 4'd13, 8'h55);
    step(1'b0, 1'b0, 1'b1, 4'd12, 8'h00);
    step(1'b0, 1'b1, 1'b0, 4'd11, 8'h9A);
    step(1'b0, 1'b0, 1'b1, 4'd11, 8'h00); #2;
    chk("lit_rd11", {24'h0, RdData}, 32'h9A);
    step(1'b0, 1'b1, 1'b0, 4'd15, 8'h66);
    idle();

    // combined accesses with one side rejected
    step(1'b0, 1'b1, 1'b1, 4'd3, 8'hEE);
    step(1'b0, 1'b1, 1'b1, 4'd14, 8'h44);
    idle();

    // same-value rewrite still pulses; back-to-back traffic
    step(1'b0, 1'b1, 1'b0, 4'd1, 8'hA5); #2;
    chk("lit_rewrite", {28'h0, REG_UPD}, 32'h2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 4'(i), 8'(8'h40 + i));
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 4'(i), 8'h00);
    for (int i = 4; i < 12; i++) step(1'b0, 1'b1, 1'b1, 4'(i), 8'(8'hC0 + i));

    // reset overrides a concurrent access
    step(1'b0, 1'b1, 1'b0, 4'd0, 8'h12);
    step(1'b1, 1'b1, 1'b1, 4'd0, 8'h77); #2;
    chk("lit_rst_ovr", {25'h0, Err, RdData_Valid, REG_UPD, REG_EXP[7:0] != 8'h00},
        32'h0);
    idle(); #2;
    chk("lit_rst_quiet", {30'h0, Err, RdData_Valid}, 32'h0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 8'h00); #2;
    chk("lit_rd0", {24'h0, RdData}, 32'h00);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, register width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of registers (need not be a power of two).
REQ-003 The block SHALL have parameter ADDR, default 4, address width; ADDR >= clog2(DEPTH).
REQ-004 The block SHALL have parameter NUM_EXP, default 4, count of registers 0..NUM_EXP-1 exported as ports; NUM_EXP <= DEPTH.
REQ-005 The block SHALL have parameter RO_MASK, DEPTH bits, default all 0; bit i set means register i is read-only to the bus.
REQ-006 The block SHALL have parameter RST_VAL, DEPTH*DATAWIDTH bits; register i takes slice i; default is 0x21 for reg 2, 0x08 for reg 3, 0 elsewhere.
REQ-007 The block SHALL use one clock; reset is synchronous and active-high.
REQ-008 CLK  in  1  clock, all state on rising edge.
REQ-009 RST  in  1  synchronous active-high reset.
REQ-010 Address  in  ADDR  register index for the current access.
REQ-011 WrEn  in  1  write request, one access per cycle.
REQ-012 RdEn  in  1  read request.
REQ-013 WrData  in  DATAWIDTH  write data.
REQ-014 RdData  out  DATAWIDTH  registered read data.
REQ-015 RdData_Valid  out  1  one-cycle pulse qualifying RdData.
REQ-016 Err  out  1  one-cycle pulse flagging a rejected access.
REQ-017 REG_EXP  out  NUM_EXP*DATAWIDTH  live contents of registers 0..NUM_EXP-1, reg i in slice i.
REQ-018 REG_UPD  out  NUM_EXP  per-register one-cycle pulse on an accepted write.

Function
REQ-019 An accepted write SHALL need WrEn=1, Address<DEPTH and RO_MASK[Address]=0; the register updates at that edge and is visible on REG_EXP in the next cycle.
REQ-020 A read SHALL register RdData and assert RdData_Valid for exactly one cycle after the RdEn cycle (latency 1).
REQ-021 With WrEn=1 and RdEn=1 together, the block SHALL perform both; RdData returns the pre-write value (read-before-write).
REQ-022 Without a read, RdData SHALL hold its last value and RdData_Valid SHALL be 0.
REQ-023 A read with Address>=DEPTH SHALL return 0 with RdData_Valid=1 and Err=1 in the same cycle.
REQ-024 A write with Address>=DEPTH or to a RO_MASK register SHALL leave storage unchanged and pulse Err one cycle later.
REQ-025 If a combined access has one rejected side, Err SHALL pulse once and the legal side SHALL still complete.
REQ-026 REG_UPD[i] SHALL pulse one cycle after an accepted write to register i (i<NUM_EXP), including rewrites of the same value.
REQ-027 A RO register SHALL change only through reset.
REQ-028 Back-to-back accesses SHALL be accepted every cycle; no busy state.

Reset
REQ-029 While RST=1, the block SHALL load register i with RST_VAL slice i and drive RdData=0, RdData_Valid=0, Err=0, REG_UPD=0.
REQ-030 RST SHALL override any concurrent WrEn/RdEn; an access in the reset cycle is discarded with no Err or Valid pulse afterwards.
REQ-031 REG_EXP SHALL show the RST_VAL slices in the first cycle after reset deassertion.

Structure
REQ-032 A shared package SHALL hold the default DATAWIDTH/DEPTH/ADDR values, the default RST_VAL vector and register index constants for regs 0..3.
REQ-033 The block SHALL be a single module with no sub-modules; the address-check/decode logic stays inline.

Verification
REQ-034 Reset then read regs 2 and 3 -> RdData 0x21 then 0x08, each with a one-cycle Valid pulse; REG_EXP slice 2 = 0x21.
REQ-035 Write 0xA5 to reg 1, then read reg 1 -> REG_UPD[1] pulses, REG_EXP slice 1 = 0xA5, RdData = 0xA5 one cycle after RdEn.
REQ-036 Reg 5 holds 0x11; WrEn+RdEn to reg 5 with WrData 0x3C -> RdData 0x11, then a read returns 0x3C.
REQ-037 RO_MASK bit 3 set, write 0xFF to reg 3 -> Err pulses one cycle, reg 3 stays 0x08, REG_UPD[3] stays 0.
REQ-038 DEPTH=12, read address 13 -> RdData 0, Valid=1, Err=1; write to 13 -> Err pulse, no storage change.
REQ-039 RST asserted in the same cycle as a write of 0x77 to reg 0 -> reg 0 = 0 afterwards, no Err, REG_UPD or Valid pulse.
